t_strobe_debounce: RTL and testbench
====================================

// Module: t_strobe_debounce
// PURPOSE
//   Upstream stage for T_ff_enable_behavior: turns a raw, bouncy push-button into a clean
//   debounced level and a single-cycle T strobe, one per accepted press.
//   Contains a 2-FF synchronizer, a stability counter and a 4-state debounce FSM.
//   The T output drives the T input of the toggle flip-flop on the same Clk.
// PARAMETERS
//   DEBOUNCE_CYCLES  4  consecutive stable synchronized cycles needed to accept a level change (>=1)
//   CNT_W            4  stability counter width; must satisfy DEBOUNCE_CYCLES <= 2**CNT_W
// PORTS
//   Clk        input   1      system clock, all state on rising edge
//   reset      input   1      asynchronous, active-high reset
//   btn_in     input   1      raw button, asynchronous to Clk, may bounce
//   T          output  1      registered one-cycle strobe per accepted press (to T-ff T input)
//   btn_level  output  1      registered debounced button level
//   busy       output  1      1 while FSM is in PRESS_WAIT or RELEASE_WAIT
// BEHAVIOUR
//   - Reset (async, any time): sync FFs=0, cnt=0, state=IDLE, T=0, btn_level=0, busy=0.
//     Takes effect immediately, not at the next edge; operation restarts from IDLE on release.
//   - Synchronizer: s1<=btn_in, btn_s<=s1; the FSM uses only btn_s.
//   - FSM (all transitions on the rising Clk edge):
//     IDLE:         btn_s=1 -> PRESS_WAIT, cnt<=0.
//     PRESS_WAIT:   btn_s=0 -> IDLE (bounce rejected, no strobe);
//                   else cnt==DEBOUNCE_CYCLES-1 -> PRESSED with T<=1; else cnt<=cnt+1.
//     PRESSED:      btn_s=0 -> RELEASE_WAIT, cnt<=0.
//     RELEASE_WAIT: btn_s=1 -> PRESSED (release bounce, NO strobe);
//                   else cnt==DEBOUNCE_CYCLES-1 -> IDLE; else cnt<=cnt+1.
//   - T: 1 for exactly the first cycle after a PRESS_WAIT->PRESSED transition, 0 otherwise.
//     Never high on two consecutive cycles.
//   - btn_level: 1 in PRESSED and RELEASE_WAIT, 0 in IDLE and PRESS_WAIT.
//     Registered; changes on the same edge as the state.
//   - Latency: btn_in goes high and stays stable before edge e0 -> btn_s=1 after e1 ->
//     PRESS_WAIT after e2 -> PRESSED with T=1 after edge e(2+DEBOUNCE_CYCLES).
//     With default 4, T is high in the cycle after the 6th edge counted from e0.
//   - Counter: saturates by construction because the FSM leaves the wait state at
//     DEBOUNCE_CYCLES-1. Counter wrap is impossible when CNT_W meets the parameter rule.
//   - Button held through reset release: the press is re-debounced from IDLE and produces one T.
//   - Button held indefinitely: one T only; stays in PRESSED.
//   - Glitch shorter than 2 Clk: may enter PRESS_WAIT; returns to IDLE, no T.
// TESTING (DEBOUNCE_CYCLES=4, Clk period 20 ns, DUT chained to T_ff_enable_behavior)
//   1 reset=1 for 25 ns with btn_in=1 -> T=0, btn_level=0, busy=0 during reset;
//     after release exactly one T pulse and btn_level=1.
//   2 Clean press: btn_in 0->1 held 400 ns -> one T pulse 6 edges after the first capture
//     edge; downstream Q toggles once; no second T.
//   3 Press bounce: btn_in toggles 1/0 every 30 ns for 150 ns, then holds 1 -> no T during
//     bouncing; exactly one T after the stable period.
//   4 Release bounce: from PRESSED, btn_in 0 for 40 ns, then 1 again -> returns to PRESSED,
//     T stays 0, btn_level stays 1.
//   5 Two clean presses separated by 200 ns of btn_in=0 -> exactly two T pulses;
//     downstream Q returns to its starting value.
//   6 reset pulse 5 ns in mid-PRESS_WAIT (asynchronous to Clk) -> state=IDLE, busy=0
//     immediately; btn still 1 -> new debounce, one T.

Source files
------------

// File: rtl/t_strobe_debounce.sv
// ---------------------------------------------------------------------------
// t_strobe_debounce
//   Turns a raw, bouncy push-button into a clean debounced level plus a
//   single-cycle T strobe (one per accepted press) for a downstream toggle
//   flip-flop clocked on the same Clk.
//
//   Clk        in   system clock, all state on rising edge
//   reset      in   asynchronous, active-high reset
//   btn_in     in   raw button, asynchronous to Clk, may bounce
//   T          out  registered one-cycle strobe per accepted press
//   btn_level  out  registered debounced button level
//   busy       out  1 while a level change is being qualified
//
//   state        | meaning
//   IDLE         | button released and stable
//   PRESS_WAIT   | synchronized button high, counting stable cycles
//   PRESSED      | press accepted, button held
//   RELEASE_WAIT | synchronized button low, counting stable cycles
// ---------------------------------------------------------------------------
module t_strobe_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 4
) (
  input  logic Clk,
  input  logic reset,
  input  logic btn_in,
  output logic T,
  output logic btn_level,
  output logic busy
);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             btn_s_q, btn_s_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             t_q, t_d;
  logic             level_q, level_d;
  logic             busy_q, busy_d;

  always_comb begin
    s1_d    = btn_in;
    btn_s_d = s1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (btn_s_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          t_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!btn_s_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        // A high sample here is release bounce: back to PRESSED without a strobe.
        if (btn_s_q) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they register on the same
    // edge as the state change.
    level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    busy_d  = (state_d == PRESS_WAIT) || (state_d == RELEASE_WAIT);
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b0;
      btn_s_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      t_q     <= 1'b0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      btn_s_q <= btn_s_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      level_q <= level_d;
      busy_q  <= busy_d;
    end
  end

  assign T         = t_q;
  assign btn_level = level_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_t_strobe_debounce.sv
module tb_t_strobe_debounce;

  localparam int DB = 4;

  logic Clk;
  logic reset;
  logic btn_in;
  logic T;
  logic btn_level;
  logic busy;

  int checks = 0;
  int errors = 0;

  t_strobe_debounce #(.DEBOUNCE_CYCLES(DB), .CNT_W(4)) dut (
    .Clk       (Clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .T         (T),
    .btn_level (btn_level),
    .busy      (busy)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  // Reference model: the FSM sees btn_in two edges late; the debounced level
  // flips once the samples seen have disagreed with it on DB+1 consecutive
  // edges. busy means a disagreement run is in progress; T follows a rise.
  logic pipe [$];
  int   diff_run;
  logic m_level, m_t, m_busy;
  int   t_seen;
  int   tick_idx;
  int   t_first;

  task automatic model_reset();
    pipe = '{1'b0, 1'b0};
    diff_run = 0;
    m_level = 1'b0;
    m_t = 1'b0;
    m_busy = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input logic b);
    logic seen;
    btn_in = b;
    @(posedge Clk);
    seen = pipe.pop_front();
    pipe.push_back(b);
    m_t = 1'b0;
    if (seen != m_level) begin
      diff_run++;
      if (diff_run == DB + 1) begin
        m_level = seen;
        m_t = seen;
        diff_run = 0;
      end
    end else begin
      diff_run = 0;
    end
    m_busy = (diff_run != 0);
    #1;
    check("T", {31'd0, T}, {31'd0, m_t});
    check("btn_level", {31'd0, btn_level}, {31'd0, m_level});
    check("busy", {31'd0, busy}, {31'd0, m_busy});
    if (T === 1'b1) begin
      if (t_seen == 0) t_first = tick_idx;
      t_seen++;
    end
    tick_idx++;
  endtask

  task automatic ticks(input logic b, input int n);
    for (int i = 0; i < n; i++) tick(b);
  endtask

  task automatic clear_counts();
    t_seen = 0;
    tick_idx = 0;
    t_first = -1;
  endtask

  initial begin
    int  len;
    logic v;

    // 1: reset held with the button already pressed
    model_reset();
    clear_counts();
    reset  = 1'b1;
    btn_in = 1'b1;
    #12;
    check("rst_T", {31'd0, T}, 32'd0);
    check("rst_level", {31'd0, btn_level}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    #13 reset = 1'b0;
    ticks(1'b1, 14);
    check("held_through_reset_tcount", t_seen, 32'd1);
    check("held_through_reset_level", {31'd0, btn_level}, 32'd1);
    ticks(1'b0, 10);

    // 2: clean press, first capture edge is tick 0, strobe after edge 6
    clear_counts();
    ticks(1'b1, 20);
    check("clean_tcount", t_seen, 32'd1);
    check("clean_latency", t_first, 32'd6);
    ticks(1'b0, 10);

    // 3: press bounce with runs too short to qualify, then a stable hold
    clear_counts();
    v = 1'b1;
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(1, 3);
      ticks(v, len);
      v = ~v;
    end
    ticks(1'b0, 1);
    check("bounce_no_t", t_seen, 32'd0);
    ticks(1'b1, 12);
    check("bounce_tcount", t_seen, 32'd1);

    // 4: release bounce from PRESSED
    clear_counts();
    ticks(1'b0, 2);
    ticks(1'b1, 8);
    check("rel_bounce_tcount", t_seen, 32'd0);
    check("rel_bounce_level", {31'd0, btn_level}, 32'd1);
    ticks(1'b0, 10);

    // 5: two clean presses
    clear_counts();
    ticks(1'b1, 12);
    ticks(1'b0, 10);
    ticks(1'b1, 12);
    ticks(1'b0, 10);
    check("two_press_tcount", t_seen, 32'd2);

    // 6: async reset pulse in the middle of PRESS_WAIT
    clear_counts();
    ticks(1'b1, 4);
    check("mid_pw_busy", {31'd0, busy}, 32'd1);
    #4 reset = 1'b1;
    #1;
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_level", {31'd0, btn_level}, 32'd0);
    model_reset();
    #4 reset = 1'b0;
    ticks(1'b1, 12);
    check("after_async_rst_tcount", t_seen, 32'd1);
    ticks(1'b0, 10);

    // Random runs of mixed lengths against the model
    for (int r = 0; r < 80; r++) begin
      len = $urandom_range(1, 8);
      ticks(1'($urandom_range(0, 1)), len);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
